// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one register-file write port among N_REQ writeback sources.
// Define REG_ZERO_PROTECT_EN to make register 0 hardwired zero (writes to it are dropped).
module reg_write_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int N_REQ  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*WIDTH-1:0]    req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [WIDTH-1:0]          Rd,
  output logic [(1<<ADDR_W)-1:0]    CP_o,
  output logic                      Reg_Write_i,
  output logic [CNT_W-1:0]          commit_cnt
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int NREG  = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PTR_W-1:0]  nxt_ptr;
  logic [N_REQ-1:0]  gnt_oh;
  logic              gnt_any;
  logic [ADDR_W-1:0] gnt_addr;
  logic [WIDTH-1:0]  gnt_data;
  logic [NREG-1:0]   gnt_dec;
  logic              wr_en;

  // Search starts at rr_ptr and wraps, so the last winner drops to lowest priority.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] ip;
    gnt_oh  = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    ip      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      ip = PTR_W'(idx);
      if (!gnt_any && req_valid[ip]) begin
        gnt_any = 1'b1;
        gnt_idx = ip;
      end
    end
    gnt_oh[gnt_idx] = gnt_any;
  end

  always_comb begin
    gnt_addr = '0;
    gnt_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_oh[i]) begin
        gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
        gnt_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign req_ready = reset ? '0 : gnt_oh;
  assign gnt_dec   = NREG'(1) << gnt_addr;

  assign nxt_ptr = (gnt_idx == PTR_W'(N_REQ - 1)) ?
                   '0 : gnt_idx + PTR_W'(1);

`ifdef REG_ZERO_PROTECT_EN
  assign wr_en = gnt_any && (gnt_addr != '0);
`else
  assign wr_en = gnt_any;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      Rd          <= '0;
      CP_o        <= '0;
      Reg_Write_i <= 1'b0;
      commit_cnt  <= '0;
    end else begin
      Reg_Write_i <= wr_en;
      CP_o        <= wr_en ? gnt_dec : '0;
      if (wr_en) Rd <= gnt_data;
      if (gnt_any) rr_ptr <= nxt_ptr;
      if (wr_en && commit_cnt != CNT_MAX)
        commit_cnt <= commit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus
// randomized traffic against a queue-free round-robin reference model.
module tb_reg_write_arbiter;

  localparam int N  = 2;
  localparam int CW = 16;
`ifdef REG_ZERO_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [9:0]  req_addr = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  req_ready;
  logic [31:0] Rd;
  logic [31:0] CP_o;
  logic        Reg_Write_i;
  logic [15:0] commit_cnt;

  logic [2:0]  s_valid = '0;
  logic [14:0] s_addr = '0;
  logic [23:0] s_data = '0;
  logic [2:0]  s_ready;
  logic [7:0]  s_rd;
  logic [31:0] s_cp;
  logic        s_we;
  logic [3:0]  s_cnt;

  reg_write_arbiter #(.WIDTH(32), .ADDR_W(5), .N_REQ(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .Rd(Rd), .CP_o(CP_o),
    .Reg_Write_i(Reg_Write_i), .commit_cnt(commit_cnt));

  reg_write_arbiter #(.WIDTH(8), .ADDR_W(5), .N_REQ(3), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .req_valid(s_valid), .req_addr(s_addr),
    .req_data(s_data), .req_ready(s_ready), .Rd(s_rd), .CP_o(s_cp),
    .Reg_Write_i(s_we), .commit_cnt(s_cnt));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int          m_ptr, m_cnt;
  bit          m_we;
  logic [31:0] m_cp, m_rd;
  logic [31:0] m_reg [32];
  int          p_g;
  logic [4:0]  p_addr;
  logic [31:0] p_data;

  function automatic int model_grant(input logic [1:0] v);
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (((v >> j) & 2'b01) != 2'b00) return j;
    end
    return -1;
  endfunction

  function automatic logic [1:0] oh(input int g);
    return (g < 0) ? 2'b00 : (2'b01 << g);
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_cnt = 0; m_we = 0; m_cp = '0; m_rd = '0;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    p_g    = model_grant(v);
    p_addr = (p_g == 1) ? a1 : a0;
    p_data = (p_g == 1) ? d1 : d0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (p_g >= 0) begin
      m_ptr = (p_g + 1) % N;
      if (PROT && p_addr == 5'd0) begin
        m_we = 0; m_cp = '0;
      end else begin
        m_we = 1;
        m_cp = 32'b1 << p_addr;
        m_rd = p_data;
        m_reg[p_addr] = p_data;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end
    end else begin
      m_we = 0; m_cp = '0;
    end
  endtask

  task automatic do_reset();
    req_valid = '0; s_valid = '0;
    reset = 1'b1; #2;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    model_reset();
    n_cmp++; if (Reg_Write_i !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", Reg_Write_i); end
    n_cmp++; if (CP_o !== 32'h0) begin n_err++; $display("FAIL reset_cp got %h want 0", CP_o); end
    n_cmp++; if (Rd !== 32'h0) begin n_err++; $display("FAIL reset_rd got %h want 0", Rd); end
    n_cmp++; if (commit_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", commit_cnt); end
    reset = 1'b0; #1;
    drive(2'b01, 5'd9, 5'd0, 32'h55, 32'h0);
    tick();
    n_cmp++; if (Reg_Write_i !== m_we) begin n_err++; $display("FAIL pre_reset_we got %b want %b", Reg_Write_i, m_we); end
    drive(2'b11, 5'd1, 5'd2, 32'hA, 32'hB);
    n_cmp++; if (req_ready !== oh(p_g)) begin n_err++; $display("FAIL pre_reset_ready got %b want %b", req_ready, oh(p_g)); end
    reset = 1'b1; #1;
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL mid_reset_ready got %b want 00", req_ready); end
    n_cmp++; if (Reg_Write_i !== 1'b0) begin n_err++; $display("FAIL mid_reset_we got %b want 0", Reg_Write_i); end
    n_cmp++; if (CP_o !== 32'h0) begin n_err++; $display("FAIL mid_reset_cp got %h want 0", CP_o); end
    n_cmp++; if (commit_cnt !== 16'h0) begin n_err++; $display("FAIL mid_reset_cnt got %0d want 0", commit_cnt); end
    reset = 1'b0;
    model_reset();
    drive(2'b11, 5'd1, 5'd2, 32'hA, 32'hB);
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL post_reset_ready got %b want 01", req_ready); end
    tick();
    n_cmp++; if (CP_o !== 32'h2) begin n_err++; $display("FAIL post_reset_cp got %h want 2", CP_o); end
    req_valid = '0;
  endtask

  task automatic test_single_write();
    do_reset();
    drive(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready got %b want 01", req_ready); end
    tick();
    n_cmp++; if (Reg_Write_i !== 1'b1) begin n_err++; $display("FAIL single_we got %b want 1", Reg_Write_i); end
    n_cmp++; if (CP_o !== 32'h20) begin n_err++; $display("FAIL single_cp got %h want 20", CP_o); end
    n_cmp++; if (Rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_rd got %h want deadbeef", Rd); end
    n_cmp++; if (commit_cnt !== 16'd1) begin n_err++; $display("FAIL single_cnt got %0d want 1", commit_cnt); end
    drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick();
    n_cmp++; if (Reg_Write_i !== 1'b0 || CP_o !== 32'h0) begin n_err++; $display("FAIL idle_port got we=%b cp=%h want 0/0", Reg_Write_i, CP_o); end
  endtask

  task automatic test_contention();
    logic [31:0] d0, d1;
    do_reset();
    d0 = $urandom; d1 = $urandom;
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 5'd1, 5'd2, d0, d1);
      n_cmp++; if (req_ready !== (2'b01 << (i % 2))) begin n_err++; $display("FAIL cont_ready[%0d] got %b want %b", i, req_ready, 2'b01 << (i % 2)); end
      tick();
      n_cmp++; if (CP_o !== m_cp || Rd !== m_rd || Reg_Write_i !== m_we) begin
        n_err++; $display("FAIL cont_port[%0d] got cp=%h rd=%h we=%b want cp=%h rd=%h we=%b", i, CP_o, Rd, Reg_Write_i, m_cp, m_rd, m_we);
      end
      if (i % 2 == 0) d0 = $urandom; else d1 = $urandom;
    end
    n_cmp++; if (commit_cnt !== 16'd6) begin n_err++; $display("FAIL cont_cnt got %0d want 6", commit_cnt); end
    req_valid = '0;
  endtask

  task automatic test_same_addr();
    do_reset();
    drive(2'b11, 5'd7, 5'd7, 32'h1, 32'h2);
    tick();
    n_cmp++; if (Rd !== 32'h1 || CP_o !== 32'h80) begin n_err++; $display("FAIL same_first got rd=%h cp=%h want 1/80", Rd, CP_o); end
    drive(2'b10, 5'd7, 5'd7, 32'h1, 32'h2);
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL same_ready got %b want 10", req_ready); end
    tick();
    n_cmp++; if (Rd !== 32'h2 || CP_o !== 32'h80 || Reg_Write_i !== 1'b1) begin n_err++; $display("FAIL same_second got rd=%h cp=%h we=%b want 2/80/1", Rd, CP_o, Reg_Write_i); end
    n_cmp++; if (m_reg[7] !== Rd) begin n_err++; $display("FAIL same_final got %h want %h", Rd, m_reg[7]); end
    req_valid = '0;
  endtask

  task automatic test_addr_zero();
    do_reset();
    drive(2'b01, 5'd0, 5'd0, 32'hFFFF, 32'h0);
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL zero_ready got %b want 01", req_ready); end
    tick();
    n_cmp++; if (Reg_Write_i !== !PROT) begin n_err++; $display("FAIL zero_we got %b want %b", Reg_Write_i, !PROT); end
    n_cmp++; if (CP_o !== (PROT ? 32'h0 : 32'h1)) begin n_err++; $display("FAIL zero_cp got %h want %h", CP_o, PROT ? 32'h0 : 32'h1); end
    n_cmp++; if (commit_cnt !== (PROT ? 16'd0 : 16'd1)) begin n_err++; $display("FAIL zero_cnt got %0d want %0d", commit_cnt, PROT ? 0 : 1); end
    drive(2'b11, 5'd3, 5'd4, 32'h3, 32'h4);
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL zero_ptr got %b want 10", req_ready); end
    tick();
    req_valid = '0;
  endtask

  task automatic test_random();
    bit          pend [2];
    logic [4:0]  a [2];
    logic [31:0] d [2];
    int          waitc [2];
    do_reset();
    for (int i = 0; i < 2; i++) begin pend[i] = 0; waitc[i] = 0; a[i] = '0; d[i] = '0; end
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1; a[i] = 5'($urandom); d[i] = $urandom;
        end
      end
      drive({pend[1], pend[0]}, a[0], a[1], d[0], d[1]);
      n_cmp++; if (req_ready !== oh(p_g)) begin n_err++; $display("FAIL rand_ready[%0d] got %b want %b", c, req_ready, oh(p_g)); end
      if (p_g >= 0) begin
        n_cmp++; if (waitc[p_g] >= N) begin n_err++; $display("FAIL starve[%0d] got wait %0d want <%0d", c, waitc[p_g], N); end
      end
      for (int i = 0; i < 2; i++) begin
        if (i == p_g) begin pend[i] = 0; waitc[i] = 0; end
        else if (pend[i]) waitc[i]++;
      end
      tick();
      n_cmp++; if (Reg_Write_i !== m_we || CP_o !== m_cp || (m_we && Rd !== m_rd) || commit_cnt !== 16'(m_cnt)) begin
        n_err++; $display("FAIL rand_port[%0d] got we=%b cp=%h rd=%h cnt=%0d want we=%b cp=%h rd=%h cnt=%0d", c, Reg_Write_i, CP_o, Rd, commit_cnt, m_we, m_cp, m_rd, m_cnt);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_saturation();
    do_reset();
    s_valid = 3'b111;
    s_addr  = {5'd3, 5'd2, 5'd1};
    s_data  = 24'h33_22_11;
    for (int k = 0; k < 20; k++) begin
      #1;
      n_cmp++; if (s_ready !== (3'b001 << (k % 3))) begin n_err++; $display("FAIL sat_ready[%0d] got %b want %b", k, s_ready, 3'b001 << (k % 3)); end
      @(posedge clk); #1;
      n_cmp++; if (s_cnt !== 4'((k + 1 > 15) ? 15 : k + 1) || s_we !== 1'b1 || s_cp !== (32'h2 << (k % 3))) begin
        n_err++; $display("FAIL sat_port[%0d] got cnt=%0d we=%b cp=%h want cnt=%0d we=1 cp=%h", k, s_cnt, s_we, s_cp, (k + 1 > 15) ? 15 : k + 1, 32'h2 << (k % 3));
      end
    end
    s_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_same_addr();
    test_addr_zero();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
